// File: rtl/signed_seq_multiplier_if.sv
// Operand/result bundle for signed_seq_multiplier.
// The master drives the start, load and multiplicand signals; the slave (the multiplier)
// drives the product registers and status flags.
interface signed_seq_multiplier_if #(
  parameter int unsigned WIDTH = 8
);
  logic             Run;
  logic             ClearA_LoadB;
  logic [WIDTH-1:0] S;
  logic [WIDTH-1:0] Aval;
  logic [WIDTH-1:0] Bval;
  logic             X;
  logic             Busy;
  logic             Done;

  modport master (
    output Run, ClearA_LoadB, S,
    input  Aval, Bval, X, Busy, Done
  );

  modport slave (
    input  Run, ClearA_LoadB, S,
    output Aval, Bval, X, Busy, Done
  );
endinterface

// File: rtl/signed_seq_multiplier.sv
// Sequential two's complement multiplier (shift-add with a final subtract for the
// multiplier's sign bit). {A,B} holds the 2N-bit product; X is A's sign extension.
// Optional build macro SEQ_MULT_FAST_EN: merges the add and shift steps into one cycle
// per multiplier bit (no SHIFT state).
module signed_seq_multiplier #(
  parameter int unsigned WIDTH = 8
) (
  input logic                   Clk,
  input logic                   Reset,
  signed_seq_multiplier_if.slave bus
);

  localparam int unsigned    CntW    = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

`ifdef SEQ_MULT_FAST_EN
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StAdd  = 2'd1,
    StDone = 2'd3
  } state_e;
`else
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StAdd   = 2'd1,
    StShift = 2'd2,
    StDone  = 2'd3
  } state_e;
`endif

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             x_q, x_d;
  logic [CntW-1:0]  cnt_q, cnt_d;

  logic [WIDTH:0] a_ext, s_ext, sum;

  // Sign-extended add; the last multiplier bit carries negative weight, so subtract there.
  always_comb begin
    a_ext = {a_q[WIDTH-1], a_q};
    s_ext = {bus.S[WIDTH-1], bus.S};
    sum   = (cnt_q == LastCnt) ? (a_ext - s_ext) : (a_ext + s_ext);
  end

  // Next-state and datapath updates.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    x_d     = x_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        // Run has priority: B keeps its value so back-to-back runs reuse the low half.
        if (bus.Run) begin
          a_d     = '0;
          x_d     = 1'b0;
          cnt_d   = '0;
          state_d = StAdd;
        end else if (bus.ClearA_LoadB) begin
          a_d = '0;
          x_d = 1'b0;
          b_d = bus.S;
        end
      end
      StAdd: begin
        if (b_q[0]) begin
          a_d = sum[WIDTH-1:0];
          x_d = sum[WIDTH];
        end
`ifdef SEQ_MULT_FAST_EN
        // Shift the freshly added value in the same cycle.
        b_d     = {a_d[0], b_q[WIDTH-1:1]};
        a_d     = {x_d, a_d[WIDTH-1:1]};
        cnt_d   = cnt_q + CntW'(1);
        state_d = (cnt_q == LastCnt) ? StDone : StAdd;
`else
        state_d = StShift;
`endif
      end
`ifndef SEQ_MULT_FAST_EN
      StShift: begin
        b_d     = {a_q[0], b_q[WIDTH-1:1]};
        a_d     = {x_q, a_q[WIDTH-1:1]};
        cnt_d   = cnt_q + CntW'(1);
        state_d = (cnt_q == LastCnt) ? StDone : StAdd;
      end
`endif
      StDone: begin
        // Wait for Run to drop so one request yields exactly one product.
        if (!bus.Run) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers; reset aborts any operation in progress.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      x_q     <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      x_q     <= x_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs decoded straight from registers so reset clears them without a clock.
  always_comb begin
    bus.Aval = a_q;
    bus.Bval = b_q;
    bus.X    = x_q;
    bus.Done = (state_q == StDone);
    bus.Busy = (state_q != StIdle) && (state_q != StDone);
  end

endmodule

// File: tb/tb_signed_seq_multiplier.sv
// Directed bench for signed_seq_multiplier at WIDTH=8.
module tb_signed_seq_multiplier;

  localparam int unsigned N = 8;
`ifdef SEQ_MULT_FAST_EN
  localparam int Lat = 8;   // edges after the Run-sampling edge until Done
`else
  localparam int Lat = 16;
`endif

  logic Clk;
  logic Reset;
  int   errors;
  int   checks;

  signed_seq_multiplier_if #(.WIDTH(N)) bus ();

  signed_seq_multiplier #(.WIDTH(N)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic load_b(input logic [7:0] b);
    bus.S            = b;
    bus.ClearA_LoadB = 1'b1;
    tick();
    bus.ClearA_LoadB = 1'b0;
  endtask

  // Pulse Run for one edge, wait for Done, check latency and product, return to IDLE.
  task automatic mult(input string tag, input logic [7:0] s, input logic [7:0] ea,
                      input logic [7:0] eb, input logic ex, input bit mid_clr);
    int n;
    bus.S   = s;
    bus.Run = 1'b1;
    tick();
    bus.Run = 1'b0;
    n = 0;
    while (!bus.Done && n < 100) begin
      if (mid_clr && n == 3) bus.ClearA_LoadB = 1'b1;
      if (mid_clr && n == 5) bus.ClearA_LoadB = 1'b0;
      tick();
      n++;
    end
    bus.ClearA_LoadB = 1'b0;
    check({tag, "_latency"}, n, Lat);
    check({tag, "_A"}, {24'd0, bus.Aval}, {24'd0, ea});
    check({tag, "_B"}, {24'd0, bus.Bval}, {24'd0, eb});
    check({tag, "_X"}, {31'd0, bus.X}, {31'd0, ex});
    tick();
    check({tag, "_idle"}, {30'd0, bus.Done, bus.Busy}, 32'd0);
  endtask

  initial begin
    errors           = 0;
    checks           = 0;
    Reset            = 1'b0;
    bus.Run          = 1'b0;
    bus.ClearA_LoadB = 1'b0;
    bus.S            = '0;
    #3;
    check("reset_A", {24'd0, bus.Aval}, 32'd0);
    check("reset_B", {24'd0, bus.Bval}, 32'd0);
    check("reset_flags", {29'd0, bus.X, bus.Busy, bus.Done}, 32'd0);
    #4 Reset = 1'b1;
    tick();

    // 0x3B (59) x 0x07 = 413
    load_b(8'h3B);
    check("load_B", {24'd0, bus.Bval}, 32'h3B);
    mult("m59x7", 8'h07, 8'h01, 8'h9D, 1'b0, 1'b0);

    // Consecutive: 2 x previous low half (0x9D = -99) = -198
    mult("m2xm99", 8'h02, 8'hFF, 8'h3A, 1'b1, 1'b0);

    // 59 x -7 = -413
    load_b(8'h3B);
    mult("m59xm7", 8'hF9, 8'hFE, 8'h63, 1'b1, 1'b0);

    // -128 x -128 = +16384
    load_b(8'h80);
    mult("mmin", 8'h80, 8'h40, 8'h00, 1'b0, 1'b0);

    // -1 x -1 = 1
    load_b(8'hFF);
    mult("mneg1", 8'hFF, 8'h00, 8'h01, 1'b0, 1'b0);

    // ClearA_LoadB pulsed while busy must not reload B
    load_b(8'h3B);
    mult("mclr", 8'h07, 8'h01, 8'h9D, 1'b0, 1'b1);

    // Run held for 40 cycles: one multiply, Done held, ClearA_LoadB ignored in DONE
    load_b(8'h05);
    bus.S   = 8'h03;
    bus.Run = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (i == 30) bus.ClearA_LoadB = 1'b1;
      tick();
    end
    bus.ClearA_LoadB = 1'b0;
    check("hold_done", {31'd0, bus.Done}, 32'd1);
    check("hold_busy", {31'd0, bus.Busy}, 32'd0);
    check("hold_A", {24'd0, bus.Aval}, 32'h00);
    check("hold_B", {24'd0, bus.Bval}, 32'h0F);
    bus.Run = 1'b0;
    tick();
    check("hold_release", {30'd0, bus.Done, bus.Busy}, 32'd0);

    // Asynchronous reset mid-operation
    load_b(8'h3B);
    bus.S   = 8'h07;
    bus.Run = 1'b1;
    tick();
    bus.Run = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("mid_busy", {31'd0, bus.Busy}, 32'd1);
    #2 Reset = 1'b0;
    #1;
    check("abort_A", {24'd0, bus.Aval}, 32'd0);
    check("abort_B", {24'd0, bus.Bval}, 32'd0);
    check("abort_flags", {29'd0, bus.X, bus.Busy, bus.Done}, 32'd0);
    #1 Reset = 1'b1;
    tick();

    // Normal operation after reset: -128 x 1 = -128
    load_b(8'h80);
    mult("post_rst", 8'h01, 8'hFF, 8'h80, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
